// File: rtl/axil_shell_pkg.sv
// Shared definitions for the AXI4-Lite FIFO/CSR shell.
// Contents: response codes, the word-index base of each address region (computed from the
// resource counts), and the write/read channel FSM state types.
package axil_shell_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {WIdle, WResp} wr_state_e;
    typedef enum logic {RIdle, RResp} rd_state_e;

    // Region order: PS2PL data, PS2PL free, PL2PS data, PL2PS occupancy, CSRs.
    // PS2PL data always starts at word 0.
    function automatic int unsigned free_base(input int unsigned n_ps2pl);
        return n_ps2pl;
    endfunction

    function automatic int unsigned pl2ps_base(input int unsigned n_ps2pl);
        return 2 * n_ps2pl;
    endfunction

    function automatic int unsigned occ_base(input int unsigned n_ps2pl,
                                             input int unsigned n_pl2ps);
        return 2 * n_ps2pl + n_pl2ps;
    endfunction

    function automatic int unsigned csr_base(input int unsigned n_ps2pl,
                                             input int unsigned n_pl2ps);
        return 2 * (n_ps2pl + n_pl2ps);
    endfunction

    // First word index that decodes as DECERR.
    function automatic int unsigned decode_end(input int unsigned n_ps2pl,
                                               input int unsigned n_pl2ps,
                                               input int unsigned n_regs);
        return 2 * (n_ps2pl + n_pl2ps) + n_regs;
    endfunction

endpackage

// File: rtl/axil_fifo_csr_shell_if.sv
// AXI4-Lite bus bundle for the FIFO/CSR shell.
// slave modport: used by the shell; master modport: used by the host side.
interface axil_fifo_csr_shell_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_shell_fifo.sv
// Synchronous FIFO used for every PS2PL and PL2PS channel of the shell.
// Ports: clk/rst (async active-high), push_v/push_data (ignored when full),
// pop (ignored when empty), head_data/head_v, full, count (occupancy).
module axil_shell_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_v,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_v,
    output logic              full,
    output logic [CNT_W-1:0]  count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok, pop_ok;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign head_v    = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // A push while full is rejected even if a pop happens in the same cycle.
    assign push_ok = push_v && !full;
    assign pop_ok  = pop && head_v;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
        end
    end
endmodule

// File: rtl/axil_fifo_csr_shell.sv
// AXI4-Lite slave exposing CSRs, PS-to-PL FIFOs, PL-to-PS FIFOs and their counters.
// Ports: aclk/areset (async active-high), s_axil (AXI4-Lite slave bundle),
// csr_o (flattened CSRs), ps2pl_data_o/v_o/yumi_i (PL consumer side of PS2PL FIFOs),
// pl2ps_data_i/v_i/ready_o (PL producer side of PL2PS FIFOs).
module axil_fifo_csr_shell
    import axil_shell_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned NUM_PS2PL  = 2,
    parameter int unsigned NUM_PL2PS  = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    axil_fifo_csr_shell_if.slave          s_axil,
    output logic [NUM_REGS*DATA_W-1:0]    csr_o,
    output logic [NUM_PS2PL*DATA_W-1:0]   ps2pl_data_o,
    output logic [NUM_PS2PL-1:0]          ps2pl_v_o,
    input  logic [NUM_PS2PL-1:0]          ps2pl_yumi_i,
    input  logic [NUM_PL2PS*DATA_W-1:0]   pl2ps_data_i,
    input  logic [NUM_PL2PS-1:0]          pl2ps_v_i,
    output logic [NUM_PL2PS-1:0]          pl2ps_ready_o
);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FREE_BASE  = free_base(NUM_PS2PL);
    localparam int unsigned PL2PS_BASE = pl2ps_base(NUM_PS2PL);
    localparam int unsigned OCC_BASE   = occ_base(NUM_PS2PL, NUM_PL2PS);
    localparam int unsigned CSR_BASE   = csr_base(NUM_PS2PL, NUM_PL2PS);
    localparam int unsigned END_BASE   = decode_end(NUM_PS2PL, NUM_PL2PS, NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0]  csr_q;
    logic [NUM_PS2PL-1:0][CNT_W-1:0]  ps2pl_count;
    logic [NUM_PL2PS-1:0][CNT_W-1:0]  pl2ps_count;
    logic [NUM_PL2PS-1:0][DATA_W-1:0] pl2ps_head;
    logic [NUM_PS2PL-1:0]             ps2pl_full, ps2pl_push;
    logic [NUM_PL2PS-1:0]             pl2ps_full, pl2ps_hv, pl2ps_pop;
    logic [NUM_REGS-1:0]              csr_we;

    wr_state_e   wr_state_q;
    rd_state_e   rd_state_q;
    logic        bvalid_q, rvalid_q, arready_q;
    logic [1:0]  bresp_q, rresp_q, wr_resp_d, rd_resp_d;
    logic [DATA_W-1:0] rdata_q, rd_data_d;
    logic        wr_fire, rd_fire;
    int unsigned widx, ridx;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    // AW and W are only accepted together, so a lone AW or W simply stalls.
    assign wr_fire        = (wr_state_q == WIdle) && s_axil.awvalid && s_axil.wvalid;
    assign s_axil.awready = wr_fire;
    assign s_axil.wready  = wr_fire;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign rd_fire        = s_axil.arvalid && arready_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    assign csr_o         = csr_q;
    assign pl2ps_ready_o = ~pl2ps_full;

    for (genvar g = 0; g < NUM_PS2PL; g++) begin : g_ps2pl
        axil_shell_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (aclk),
            .rst       (areset),
            .push_v    (ps2pl_push[g]),
            .push_data (s_axil.wdata),
            .pop       (ps2pl_yumi_i[g]),
            .head_data (ps2pl_data_o[g*DATA_W +: DATA_W]),
            .head_v    (ps2pl_v_o[g]),
            .full      (ps2pl_full[g]),
            .count     (ps2pl_count[g])
        );
    end

    for (genvar g = 0; g < NUM_PL2PS; g++) begin : g_pl2ps
        axil_shell_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (aclk),
            .rst       (areset),
            .push_v    (pl2ps_v_i[g]),
            .push_data (pl2ps_data_i[g*DATA_W +: DATA_W]),
            .pop       (pl2ps_pop[g]),
            .head_data (pl2ps_head[g]),
            .head_v    (pl2ps_hv[g]),
            .full      (pl2ps_full[g]),
            .count     (pl2ps_count[g])
        );
    end

    // Write decode: effect strobes qualified by wr_fire, response computed every cycle.
    always_comb begin
        widx       = 32'(s_axil.awaddr[ADDR_W-1:2]);
        wr_resp_d  = RESP_DECERR;
        ps2pl_push = '0;
        csr_we     = '0;
        if (widx < FREE_BASE) begin
            wr_resp_d = RESP_SLVERR;
            for (int unsigned i = 0; i < NUM_PS2PL; i++) begin
                if (widx == i && !ps2pl_full[i]) begin
                    wr_resp_d     = RESP_OKAY;
                    ps2pl_push[i] = wr_fire;
                end
            end
        end else if (widx < CSR_BASE) begin
            wr_resp_d = RESP_SLVERR;
        end else if (widx < END_BASE) begin
            wr_resp_d = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (widx == CSR_BASE + i) csr_we[i] = wr_fire;
            end
        end
    end

    // Read decode: counters and heads are sampled before the accept-cycle update.
    always_comb begin
        ridx      = 32'(s_axil.araddr[ADDR_W-1:2]);
        rd_data_d = '0;
        rd_resp_d = RESP_DECERR;
        pl2ps_pop = '0;
        if (ridx < FREE_BASE) begin
            rd_resp_d = RESP_SLVERR;
        end else if (ridx < PL2PS_BASE) begin
            rd_resp_d = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_PS2PL; i++) begin
                if (ridx == FREE_BASE + i) begin
                    rd_data_d = DATA_W'(FIFO_DEPTH) - DATA_W'(ps2pl_count[i]);
                end
            end
        end else if (ridx < OCC_BASE) begin
            rd_resp_d = RESP_SLVERR;
            for (int unsigned i = 0; i < NUM_PL2PS; i++) begin
                if (ridx == PL2PS_BASE + i && pl2ps_hv[i]) begin
                    rd_data_d    = pl2ps_head[i];
                    rd_resp_d    = RESP_OKAY;
                    pl2ps_pop[i] = rd_fire;
                end
            end
        end else if (ridx < CSR_BASE) begin
            rd_resp_d = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_PL2PS; i++) begin
                if (ridx == OCC_BASE + i) rd_data_d = DATA_W'(pl2ps_count[i]);
            end
        end else if (ridx < END_BASE) begin
            rd_resp_d = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (ridx == CSR_BASE + i) rd_data_d = csr_q[i];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            csr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                for (int unsigned b = 0; b < DATA_W / 8; b++) begin
                    if (csr_we[i] && s_axil.wstrb[b]) csr_q[i][b*8 +: 8] <= s_axil.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= WIdle;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                WIdle: if (wr_fire) begin
                    wr_state_q <= WResp;
                    bvalid_q   <= 1'b1;
                    bresp_q    <= wr_resp_d;
                end
                default: if (s_axil.bready) begin
                    wr_state_q <= WIdle;
                    bvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    // arready is registered so it stays low until the first clock after reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q <= RIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                RIdle: begin
                    if (rd_fire) begin
                        rd_state_q <= RResp;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_data_d;
                        rresp_q    <= rd_resp_d;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                default: if (s_axil.rready) begin
                    rd_state_q <= RIdle;
                    rvalid_q   <= 1'b0;
                    arready_q  <= 1'b1;
                end
            endcase
        end
    end

    // The PL must only consume a head that is valid.
    assert property (@(posedge aclk) disable iff (areset) (ps2pl_yumi_i & ~ps2pl_v_o) == '0);
endmodule

// File: tb/tb_axil_fifo_csr_shell.sv
module tb_axil_fifo_csr_shell;
    typedef struct {
        logic [1:0] resp;
        string      name;
    } bexp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } rexp_t;

    localparam logic [1:0] OK = 2'b00, SE = 2'b10, DE = 2'b11;

    logic         aclk = 1'b0;
    logic         areset;
    logic [127:0] csr_o;
    logic [63:0]  ps2pl_data_o;
    logic [1:0]   ps2pl_v_o;
    logic [1:0]   ps2pl_yumi_i;
    logic [63:0]  pl2ps_data_i;
    logic [1:0]   pl2ps_v_i;
    logic [1:0]   pl2ps_ready_o;

    int    checks = 0;
    int    errors = 0;
    bexp_t bq[$];
    rexp_t rq[$];
    bexp_t be;
    rexp_t re;

    axil_fifo_csr_shell_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    axil_fifo_csr_shell #(
        .DATA_W(32), .ADDR_W(10), .NUM_REGS(4), .NUM_PS2PL(2), .NUM_PL2PS(2), .FIFO_DEPTH(8)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axil        (bus),
        .csr_o         (csr_o),
        .ps2pl_data_o  (ps2pl_data_o),
        .ps2pl_v_o     (ps2pl_v_o),
        .ps2pl_yumi_i  (ps2pl_yumi_i),
        .pl2ps_data_i  (pl2ps_data_i),
        .pl2ps_v_i     (pl2ps_v_i),
        .pl2ps_ready_o (pl2ps_ready_o)
    );

    always #5 aclk = ~aclk;

    // Monitor: compares each B/R handshake against the oldest expected response.
    always @(negedge aclk) begin
        if (!areset && bus.bvalid && bus.bready) begin
            checks++;
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: bresp=%b with nothing expected", bus.bresp);
            end else begin
                be = bq.pop_front();
                if (bus.bresp !== be.resp) begin
                    errors++;
                    $display("FAIL %s: bresp=%b expected %b", be.name, bus.bresp, be.resp);
                end
            end
        end
        if (!areset && bus.rvalid && bus.rready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected: rdata=%h rresp=%b", bus.rdata, bus.rresp);
            end else begin
                re = rq.pop_front();
                if (bus.rdata !== re.data || bus.rresp !== re.resp) begin
                    errors++;
                    $display("FAIL %s: rdata=%h rresp=%b expected %h %b",
                             re.name, bus.rdata, bus.rresp, re.data, re.resp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_aw();
        bit ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge aclk);
            ok = bus.awready && bus.wready;
            @(posedge aclk);
            #1;
        end
        if (!ok) timeout("aw_accept");
    endtask

    task automatic wait_b();
        bit ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge aclk);
            ok = bus.bvalid && bus.bready;
            @(posedge aclk);
            #1;
        end
        if (!ok) timeout("b_handshake");
    endtask

    task automatic wait_ar();
        bit ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge aclk);
            ok = bus.arready;
            @(posedge aclk);
            #1;
        end
        if (!ok) timeout("ar_accept");
    endtask

    task automatic wait_r();
        bit ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge aclk);
            ok = bus.rvalid && bus.rready;
            @(posedge aclk);
            #1;
        end
        if (!ok) timeout("r_handshake");
    endtask

    task automatic push_b(input logic [1:0] resp, input string name);
        bexp_t e;
        e.resp = resp;
        e.name = name;
        bq.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input string name);
        rexp_t e;
        e.data = data;
        e.resp = resp;
        e.name = name;
        rq.push_back(e);
    endtask

    task automatic axi_write(input logic [9:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp, input string name);
        push_b(resp, name);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        wait_aw();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_b();
    endtask

    task automatic axi_read(input logic [9:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input string name);
        push_r(data, resp, name);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        wait_ar();
        bus.arvalid = 1'b0;
        wait_r();
    endtask

    task automatic pl_push(input logic fifo, input logic [31:0] data);
        if (fifo) pl2ps_data_i[63:32] = data;
        else      pl2ps_data_i[31:0]  = data;
        pl2ps_v_i[fifo] = 1'b1;
        @(posedge aclk);
        #1;
        pl2ps_v_i[fifo] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        areset       = 1'b1;
        bus.awaddr   = '0;
        bus.awvalid  = 1'b0;
        bus.wdata    = '0;
        bus.wstrb    = '0;
        bus.wvalid   = 1'b0;
        bus.bready   = 1'b1;
        bus.araddr   = '0;
        bus.arvalid  = 1'b0;
        bus.rready   = 1'b1;
        ps2pl_yumi_i = '0;
        pl2ps_data_i = '0;
        pl2ps_v_i    = '0;

        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
        check("rst_ps2pl_v", 32'(ps2pl_v_o), 32'd0);
        check("rst_pl2ps_ready", 32'(pl2ps_ready_o), 32'd3);
        check("rst_csr", 32'(csr_o != '0), 32'd0);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("arready_after_rst", 32'(bus.arready), 32'd1);

        // CSR byte strobes.
        axi_write(10'h024, 32'hDEADBEEF, 4'b0011, OK, "csr1_wr");
        axi_read(10'h024, 32'h0000BEEF, OK, "csr1_rd");
        check("csr_o_csr1", csr_o[63:32], 32'h0000BEEF);
        check("csr_o_csr0", csr_o[31:0], 32'h0);
        axi_write(10'h02C, 32'h12345678, 4'b1111, OK, "csr3_wr_full");
        axi_write(10'h02F, 32'hAABBCCDD, 4'b1000, OK, "csr3_wr_top");
        axi_read(10'h02C, 32'hAA345678, OK, "csr3_rd");
        check("csr_o_csr3", csr_o[127:96], 32'hAA345678);

        // PS2PL fill, overflow, drain.
        for (int i = 1; i <= 9; i++) begin
            axi_write(10'h000, 32'(i), 4'b1111, (i <= 8) ? OK : SE, "ps2pl0_wr");
        end
        axi_read(10'h008, 32'd0, OK, "ps2pl0_free_full");
        axi_read(10'h00C, 32'd8, OK, "ps2pl1_free_empty");
        for (int i = 1; i <= 8; i++) begin
            check("ps2pl0_v", 32'(ps2pl_v_o[0]), 32'd1);
            check("ps2pl0_head", ps2pl_data_o[31:0], 32'(i));
            ps2pl_yumi_i[0] = 1'b1;
            @(posedge aclk);
            #1;
            ps2pl_yumi_i[0] = 1'b0;
        end
        check("ps2pl0_drained", 32'(ps2pl_v_o[0]), 32'd0);
        axi_read(10'h008, 32'd8, OK, "ps2pl0_free_drained");

        // PL2PS pop and underflow.
        pl_push(1'b1, 32'hA5);
        axi_read(10'h01C, 32'd1, OK, "pl2ps1_occ_1");
        axi_read(10'h014, 32'hA5, OK, "pl2ps1_pop");
        axi_read(10'h01C, 32'd0, OK, "pl2ps1_occ_0");
        axi_read(10'h014, 32'd0, SE, "pl2ps1_underflow");

        // Simultaneous PL push and PS pop at count 3.
        pl_push(1'b1, 32'h11);
        pl_push(1'b1, 32'h22);
        pl_push(1'b1, 32'h33);
        axi_read(10'h01C, 32'd3, OK, "pl2ps1_occ_3");
        push_r(32'h11, OK, "pl2ps1_pop_with_push");
        bus.araddr         = 10'h014;
        bus.arvalid        = 1'b1;
        pl2ps_data_i[63:32] = 32'h44;
        pl2ps_v_i[1]       = 1'b1;
        @(negedge aclk);
        check("same_cycle_arready", 32'(bus.arready), 32'd1);
        check("same_cycle_ready_o", 32'(pl2ps_ready_o[1]), 32'd1);
        @(posedge aclk);
        #1;
        bus.arvalid  = 1'b0;
        pl2ps_v_i[1] = 1'b0;
        check("after_ready_o", 32'(pl2ps_ready_o[1]), 32'd1);
        wait_r();
        axi_read(10'h01C, 32'd3, OK, "pl2ps1_occ_still_3");
        axi_read(10'h014, 32'h22, OK, "pl2ps1_order_22");
        axi_read(10'h014, 32'h33, OK, "pl2ps1_order_33");
        axi_read(10'h014, 32'h44, OK, "pl2ps1_order_44");
        axi_read(10'h01C, 32'd0, OK, "pl2ps1_occ_end");

        // Decode errors and access-type errors.
        axi_read(10'h030, 32'd0, DE, "decerr_rd");
        axi_write(10'h030, 32'hFFFFFFFF, 4'b1111, DE, "decerr_wr");
        axi_write(10'h008, 32'h5, 4'b1111, SE, "wr_free_ro");
        axi_write(10'h010, 32'h5, 4'b1111, SE, "wr_pl2ps_ro");
        axi_read(10'h000, 32'd0, SE, "rd_ps2pl_wo");
        axi_read(10'h008, 32'd8, OK, "free_unchanged");
        axi_read(10'h018, 32'd0, OK, "pl2ps0_occ_unchanged");

        // B backpressure: second write must wait for the first B to complete.
        push_b(OK, "bp_first");
        push_b(OK, "bp_second");
        bus.bready  = 1'b0;
        bus.awaddr  = 10'h020;
        bus.wdata   = 32'h11111111;
        bus.wstrb   = 4'b1111;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        wait_aw();
        bus.awaddr = 10'h028;
        bus.wdata  = 32'h22222222;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("bp_bvalid_held", 32'(bus.bvalid), 32'd1);
            check("bp_no_accept", 32'(bus.awready), 32'd0);
            @(posedge aclk);
            #1;
        end
        bus.bready = 1'b1;
        wait_b();
        wait_aw();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_b();
        axi_read(10'h020, 32'h11111111, OK, "bp_csr0");
        axi_read(10'h028, 32'h22222222, OK, "bp_csr2");

        // Reset while a read response is pending and FIFOs hold data.
        pl_push(1'b0, 32'h77);
        axi_write(10'h004, 32'h55, 4'b1111, OK, "ps2pl1_wr");
        check("pre_rst_ps2pl1_v", 32'(ps2pl_v_o[1]), 32'd1);
        bus.rready  = 1'b0;
        bus.araddr  = 10'h020;
        bus.arvalid = 1'b1;
        @(posedge aclk);
        #1;
        bus.arvalid = 1'b0;
        @(negedge aclk);
        check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("mid_rst_ps2pl_v", 32'(ps2pl_v_o), 32'd0);
        check("mid_rst_ready_o", 32'(pl2ps_ready_o), 32'd3);
        check("mid_rst_csr", 32'(csr_o != '0), 32'd0);
        check("mid_rst_rdata", bus.rdata, 32'd0);
        areset     = 1'b0;
        bus.rready = 1'b1;
        @(posedge aclk);
        #1;
        axi_read(10'h00C, 32'd8, OK, "post_rst_free1");
        axi_read(10'h018, 32'd0, OK, "post_rst_occ0");
        axi_read(10'h020, 32'd0, OK, "post_rst_csr0");

        repeat (2) @(posedge aclk);
        check("b_queue_drained", 32'(bq.size()), 32'd0);
        check("r_queue_drained", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_fifo_csr_shell.md
Name: axil_fifo_csr_shell

Overview:
- Parametrised AXI4-Lite slave shell sitting between the PS general-purpose AXI port and PL logic.
- Generalises a fixed-port AXI pass-through into four resources behind one slave:
  - NUM_REGS read/write CSRs.
  - NUM_PS2PL PS-to-PL FIFOs.
  - NUM_PL2PS PL-to-PS FIFOs.
  - Readable occupancy counters for every FIFO.
- Host software drives PL accelerators through it with flow control instead of raw register pokes.

Parameters:
- DATA_W, 32, AXI-Lite data width; all CSR and FIFO entries are DATA_W wide.
- ADDR_W, 10, AXI-Lite byte address width.
- NUM_REGS, 4, number of PS-writable CSRs (≥1).
- NUM_PS2PL, 2, number of PS-to-PL FIFOs (≥1).
- NUM_PL2PS, 2, number of PL-to-PS FIFOs (≥1).
- FIFO_DEPTH, 8, entries per FIFO, power of two, ≥2.

Ports:
- aclk  in  1  single clock for everything.
- areset  in  1  asynchronous, active-high reset.
- s_axil_awaddr  in  ADDR_W  write address.
- s_axil_awvalid/s_axil_awready  in/out  1  AW handshake.
- s_axil_wdata  in  DATA_W  write data.
- s_axil_wstrb  in  DATA_W/8  byte strobes.
- s_axil_wvalid/s_axil_wready  in/out  1  W handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid/s_axil_bready  out/in  1  B handshake.
- s_axil_araddr  in  ADDR_W  read address.
- s_axil_arvalid/s_axil_arready  in/out  1  AR handshake.
- s_axil_rdata  out  DATA_W  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid/s_axil_rready  out/in  1  R handshake.
- csr_o  out  NUM_REGS*DATA_W  flattened CSR values.
- ps2pl_data_o  out  NUM_PS2PL*DATA_W  FIFO head data.
- ps2pl_v_o  out  NUM_PS2PL  head valid per FIFO.
- ps2pl_yumi_i  in  NUM_PS2PL  PL consumes head (only when v_o).
- pl2ps_data_i  in  NUM_PL2PS*DATA_W  PL push data.
- pl2ps_v_i  in  NUM_PL2PS  PL push valid.
- pl2ps_ready_o  out  NUM_PL2PS  FIFO not full.

Behaviour:
- Address decode uses word index = addr[ADDR_W-1:2]; addr[1:0] is ignored. Regions are contiguous, in this order:
  - PS2PL data, NUM_PS2PL words, write-only.
  - PS2PL free-space counters, NUM_PS2PL words, read-only.
  - PL2PS data, NUM_PL2PS words, read-only; a read pops.
  - PL2PS occupancy counters, NUM_PL2PS words, read-only.
  - CSRs, NUM_REGS words, read/write.
  - Any index beyond the CSR region decodes as DECERR.
- Write channel FSM W_IDLE→W_RESP:
  - In W_IDLE, awready=wready=1 only when awvalid&wvalid are both high; the single-cycle accept moves to W_RESP with bvalid=1.
  - bvalid holds until bready; then back to W_IDLE.
  - At most one outstanding write.
  - AW without W (or W without AW) waits with no acceptance.
- Read channel FSM R_IDLE→R_RESP:
  - arready=1 in R_IDLE; accept latches rdata/rresp and moves to R_RESP with rvalid=1.
  - rvalid holds with stable rdata until rready; then back to R_IDLE.
- Latency: write accept to bvalid is 1 cycle; read accept to rvalid is 1 cycle.
- Response codes are OKAY=00, SLVERR=10, DECERR=11.
- CSR writes:
  - Apply wstrb per byte; resp OKAY.
  - CSR reads return the current value; resp OKAY.
- PS2PL data write:
  - If not full, push the full wdata (wstrb ignored); resp OKAY.
  - If full, drop the data; resp SLVERR.
- PL2PS data read:
  - If not empty, return the head, pop at the accept cycle; resp OKAY.
  - If empty, rdata=0, no pop; resp SLVERR.
- Writes to read-only regions have no effect; resp SLVERR. Reads of the write-only region return 0; resp SLVERR.
- DECERR cases: write has no effect; read returns rdata=0.
- Counters:
  - Free space = FIFO_DEPTH − count.
  - Occupancy = count.
  - Zero-extended to DATA_W; width $clog2(FIFO_DEPTH+1).
- FIFO semantics:
  - Simultaneous push and pop in the same cycle is allowed at any occupancy except push-when-full; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Counter reads reflect state before the accept cycle.
  - pl2ps_v_i with ready_o low is ignored (no push).
  - ps2pl_yumi_i while v_o is low is a protocol error, caught by assertion only.
- Reset (async assert, released synchronously to aclk):
  - All FIFOs empty, CSRs 0.
  - FSMs idle; bvalid=rvalid=0; awready=wready=0; arready=1 after the first clock.
  - ps2pl_v_o=0, pl2ps_ready_o=1.
  - rdata=0, bresp=rresp=00.
  - Reset mid-transaction abandons it; no response is issued.

Decomposition:
- Shared package axil_shell_pkg:
  - Response code constants.
  - Region base-offset functions of (NUM_PS2PL, NUM_PL2PS, NUM_REGS).
  - Write/read FSM state enums.
- One sub-module axil_shell_fifo:
  - Parameters DATA_W, FIFO_DEPTH.
  - Ports: push_v/data, pop, head_data/v, full, count.
  - Instantiated NUM_PS2PL+NUM_PL2PS times via generate.

Test Plan:
- CSR byte strobes: write 0xDEADBEEF to CSR1 with wstrb=0011, then read CSR1 → rdata=0x0000BEEF, OKAY; csr_o[63:32]=0x0000BEEF.
- PS2PL fill and overflow:
  - Write FIFO0 data 9 times (1..9) with yumi low → writes 1–8 OKAY, write 9 SLVERR.
  - Free-space read → 0.
  - Drain via yumi → heads 1..8 in order, then v_o=0.
- PL2PS pop and underflow:
  - Push 0xA5 on FIFO1 → occupancy read =1.
  - Data read → 0xA5, OKAY; occupancy → 0.
  - Data read again → 0, SLVERR.
- Simultaneous push and pop: FIFO at count 3, PL push and PS pop in the same cycle → count stays 3, FIFO order preserved, no ready_o drop.
- Decode and backpressure:
  - Read word index past the CSR region → DECERR, rdata=0.
  - Hold bready low 5 cycles → bvalid stays high, second write not accepted until B completes.
- Reset mid-operation: assert areset while rvalid=1 and FIFOs hold data → next cycle rvalid=0, all counts 0, csr_o=0, pl2ps_ready_o all 1.
